// File: rtl/xy_route_arbiter_pkg.sv
// Shared constants for the XY mesh switch: port indices, arbiter FSM states
// and the dimension-ordered route function.
package xy_route_arbiter_pkg;

  localparam int unsigned PORT_LOCAL = 0;
  localparam int unsigned PORT_WEST  = 1;
  localparam int unsigned PORT_EAST  = 2;
  localparam int unsigned PORT_NORTH = 3;
  localparam int unsigned PORT_SOUTH = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  // X is resolved before Y; operands arrive zero-extended so compares stay unsigned.
  function automatic logic [2:0] xy_route(input int unsigned dx, input int unsigned dy,
                                          input int unsigned cx, input int unsigned cy);
    logic [2:0] port;
    if (dx > cx)      port = 3'(PORT_EAST);
    else if (dx < cx) port = 3'(PORT_WEST);
    else if (dy > cy) port = 3'(PORT_SOUTH);
    else if (dy < cy) port = 3'(PORT_NORTH);
    else              port = 3'(PORT_LOCAL);
    return port;
  endfunction

endpackage

// File: rtl/xy_route_arbiter_if.sv
// Arbiter <-> control unit bundle. Handshake: the control unit holds vld_input_i high for a
// port with a head packet; grant_vld_o high means the selects are valid and held until a wr_en_i bit completes the transfer.
interface xy_route_arbiter_if #(
  parameter int PORT_N = 5,
  parameter int X_W    = 4,
  parameter int Y_W    = 4
);
  localparam int SEL_W = (PORT_N > 1) ? $clog2(PORT_N) : 1;

  logic [PORT_N-1:0]     vld_input_i;
  logic [PORT_N*X_W-1:0] dst_x_i;
  logic [PORT_N*Y_W-1:0] dst_y_i;
  logic [PORT_N-1:0]     wr_en_i;
  logic [SEL_W-1:0]      mux_in_sel_o;
  logic [SEL_W-1:0]      mux_out_sel_o;
  logic                  grant_vld_o;
  logic                  timeout_o;

  modport slave (
    input  vld_input_i, dst_x_i, dst_y_i, wr_en_i,
    output mux_in_sel_o, mux_out_sel_o, grant_vld_o, timeout_o
  );

  modport master (
    output vld_input_i, dst_x_i, dst_y_i, wr_en_i,
    input  mux_in_sel_o, mux_out_sel_o, grant_vld_o, timeout_o
  );
endinterface

// File: rtl/xy_route_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or above ptr_i, wrapping mod N.
module rr_picker #(
  parameter int N  = 5,
  parameter int PW = 3
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [PW-1:0] idx_o,
  output logic          any_o
);

  int            cand;
  logic [PW-1:0] cand_idx;

  // Scan from the farthest offset down so the nearest request is the last to write idx_o.
  always_comb begin
    idx_o    = ptr_i;
    any_o    = |req_i;
    cand     = 0;
    cand_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = int'(ptr_i) + k;
      if (cand >= N) cand = cand - N;
      cand_idx = PW'(cand);
      if (req_i[cand_idx]) idx_o = cand_idx;
    end
  end

endmodule

// File: rtl/xy_route_arbiter.sv
// Round-robin input arbiter with XY output routing for one mesh switch.
// Optional grant-hold watchdog enabled by defining ARB_TIMEOUT_EN.
module xy_route_arbiter
  import xy_route_arbiter_pkg::*;
#(
  parameter int PORT_N      = 5,
  parameter int X_W         = 4,
  parameter int Y_W         = 4,
  parameter int X_CORD      = 0,
  parameter int Y_CORD      = 0,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  xy_route_arbiter_if.slave bus,
  output arb_state_e        state_o
);

  localparam int SEL_W = (PORT_N > 1) ? $clog2(PORT_N) : 1;
  localparam logic [X_W-1:0] CX = X_W'(X_CORD);
  localparam logic [Y_W-1:0] CY = Y_W'(Y_CORD);

  arb_state_e       state_q;
  logic [SEL_W-1:0] rr_ptr_q;
  logic [SEL_W-1:0] in_sel_q;
  logic [SEL_W-1:0] out_sel_q;
  logic             grant_q;

  logic [SEL_W-1:0] pick_idx;
  logic             pick_any;
  logic [SEL_W-1:0] route_d;
  logic [SEL_W-1:0] next_ptr_d;
  logic             cur_vld;
  logic [X_W-1:0]   dx_arr [PORT_N];
  logic [Y_W-1:0]   dy_arr [PORT_N];

  for (genvar p = 0; p < PORT_N; p++) begin : g_unpack
    assign dx_arr[p] = bus.dst_x_i[p*X_W +: X_W];
    assign dy_arr[p] = bus.dst_y_i[p*Y_W +: Y_W];
  end

  rr_picker #(.N(PORT_N), .PW(SEL_W)) u_rr_picker (
    .req_i (bus.vld_input_i),
    .ptr_i (rr_ptr_q),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  assign route_d    = SEL_W'(xy_route(32'(dx_arr[pick_idx]), 32'(dy_arr[pick_idx]),
                                      32'(CX), 32'(CY)));
  assign next_ptr_d = (in_sel_q == SEL_W'(PORT_N - 1)) ? '0 : in_sel_q + 1'b1;
  assign cur_vld    = bus.vld_input_i[in_sel_q];

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q;
  logic             timeout_q;
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT_CYC == 0);
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= '0;
      in_sel_q  <= '0;
      out_sel_q <= '0;
      grant_q   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (pick_any) begin
            in_sel_q  <= pick_idx;
            out_sel_q <= route_d;
            grant_q   <= 1'b1;
            state_q   <= ST_GRANT;
`ifdef ARB_TIMEOUT_EN
            cnt_q     <= '0;
`endif
          end
        end
        ST_GRANT: begin
          // Completion wins over a simultaneous valid drop.
          if (|bus.wr_en_i) begin
            rr_ptr_q <= next_ptr_d;
            grant_q  <= 1'b0;
            state_q  <= ST_IDLE;
          end else if (!cur_vld) begin
            grant_q  <= 1'b0;
            state_q  <= ST_IDLE;
`ifdef ARB_TIMEOUT_EN
          end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
            rr_ptr_q  <= next_ptr_d;
            grant_q   <= 1'b0;
            state_q   <= ST_IDLE;
            timeout_q <= 1'b1;
          end else begin
            cnt_q     <= cnt_q + 1'b1;
`endif
          end
        end
        default: begin
          state_q <= ST_IDLE;
          grant_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mux_in_sel_o  = in_sel_q;
  assign bus.mux_out_sel_o = out_sel_q;
  assign bus.grant_vld_o   = grant_q;
  assign state_o           = state_q;
`ifdef ARB_TIMEOUT_EN
  assign bus.timeout_o     = timeout_q;
`else
  assign bus.timeout_o     = 1'b0;
`endif

endmodule

// File: tb/tb_xy_route_arbiter.sv
// Bench for xy_route_arbiter: directed scenarios plus random traffic against a behavioural model.
// Define ARB_TIMEOUT_EN to also exercise the watchdog.
module tb_xy_route_arbiter;
  import xy_route_arbiter_pkg::*;

  localparam int N  = 5;
  localparam int XW = 4;
  localparam int YW = 4;
  localparam int XC = 1;
  localparam int YC = 1;
  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  arb_state_e state;

  always #5 clk = ~clk;

  xy_route_arbiter_if #(.PORT_N(N), .X_W(XW), .Y_W(YW)) bus ();

  xy_route_arbiter #(
    .PORT_N(N), .X_W(XW), .Y_W(YW), .X_CORD(XC), .Y_CORD(YC), .TIMEOUT_CYC(TO)
  ) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .bus     (bus),
    .state_o (state)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int  m_ptr, m_in, m_out, m_cnt;
  bit  m_grant, m_to;
  int  dx [N];
  int  dy [N];
  bit  prev_grant;
  logic [7:0] exp_q [$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_route(input int x, input int y);
    if (x > XC) return 2;
    if (x < XC) return 1;
    if (y > YC) return 4;
    if (y < YC) return 3;
    return 0;
  endfunction

  function automatic int ref_pick(input logic [N-1:0] vld, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (vld[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic model_update(input logic [N-1:0] vld, input logic [N-1:0] wr, input bit rst);
    int p;
    logic [31:0] pi, po;
    if (rst) begin
      m_ptr = 0; m_in = 0; m_out = 0; m_cnt = 0; m_grant = 0; m_to = 0;
      exp_q.delete();
    end else begin
      m_to = 0;
      if (!m_grant) begin
        p = ref_pick(vld, m_ptr);
        if (p >= 0) begin
          m_in = p;
          m_out = ref_route(dx[p], dy[p]);
          m_grant = 1;
          m_cnt = 0;
          pi = m_in; po = m_out;
          exp_q.push_back({pi[3:0], po[3:0]});
        end
      end else if (wr != '0) begin
        m_ptr = (m_in + 1) % N;
        m_grant = 0;
      end else if (!vld[m_in]) begin
        m_grant = 0;
      end else begin
`ifdef ARB_TIMEOUT_EN
        m_cnt++;
        if (m_cnt == TO) begin
          m_ptr = (m_in + 1) % N;
          m_grant = 0;
          m_to = 1;
        end
`endif
      end
    end
  endtask

  task automatic set_dst(input int p, input int x, input int y);
    dx[p] = x;
    dy[p] = y;
  endtask

  task automatic step(input logic [N-1:0] vld, input logic [N-1:0] wr, input bit rst);
    logic [7:0] e;
    @(negedge clk);
    bus.vld_input_i = vld;
    bus.wr_en_i     = wr;
    rst_n           = ~rst;
    for (int p = 0; p < N; p++) begin
      bus.dst_x_i[p*XW +: XW] = XW'(dx[p]);
      bus.dst_y_i[p*YW +: YW] = YW'(dy[p]);
    end
    @(posedge clk);
    model_update(vld, wr, rst);
    #1;
    check_val("grant_vld", 32'(bus.grant_vld_o), 32'(m_grant));
    check_val("in_sel", 32'(bus.mux_in_sel_o), 32'(m_in));
    check_val("out_sel", 32'(bus.mux_out_sel_o), 32'(m_out));
    check_val("timeout", 32'(bus.timeout_o), 32'(m_to));
    check_val("state", 32'(state), m_grant ? 32'(ST_GRANT) : 32'(ST_IDLE));
    if (bus.grant_vld_o && !prev_grant) begin
      if (exp_q.size() == 0) begin
        check_val("sb_unexpected_grant", 32'(1), 32'(0));
      end else begin
        e = exp_q.pop_front();
        check_val("sb_grant", {24'd0, 1'b0, bus.mux_in_sel_o, 1'b0, bus.mux_out_sel_o}, {24'd0, e});
      end
    end
    prev_grant = bus.grant_vld_o;
  endtask

  logic [N-1:0] rv, rw;
  int ptab_x [3] = '{1, 1, 0};
  int ptab_y [3] = '{0, 1, 2};
  int ptab_r [3] = '{3, 0, 1};

  initial begin
    bus.vld_input_i = '0;
    bus.wr_en_i     = '0;
    bus.dst_x_i     = '0;
    bus.dst_y_i     = '0;
    prev_grant      = 0;
    for (int p = 0; p < N; p++) set_dst(p, XC, YC);
    model_update('0, '0, 1'b1);

    // Reset state
    step('0, '0, 1'b1);
    step('0, '0, 1'b1);
    check_val("rst_grant", 32'(bus.grant_vld_o), 32'd0);
    check_val("rst_in", 32'(bus.mux_in_sel_o), 32'd0);
    check_val("rst_out", 32'(bus.mux_out_sel_o), 32'd0);
    check_val("rst_to", 32'(bus.timeout_o), 32'd0);

    // Route east, then the remaining directions
    set_dst(0, 3, 1);
    step(5'b00001, '0, 1'b0);
    check_val("east_in", 32'(bus.mux_in_sel_o), 32'd0);
    check_val("east_out", 32'(bus.mux_out_sel_o), 32'd2);
    check_val("east_gv", 32'(bus.grant_vld_o), 32'd1);
    step(5'b00001, 5'b00100, 1'b0);
    check_val("east_done", 32'(bus.grant_vld_o), 32'd0);
    for (int i = 0; i < 3; i++) begin
      set_dst(0, ptab_x[i], ptab_y[i]);
      step(5'b00001, '0, 1'b0);
      check_val("route_tab", 32'(bus.mux_out_sel_o), 32'(ptab_r[i]));
      step(5'b00001, 5'b00001, 1'b0);
    end

    // Fair rotation with one idle cycle between grants
    step('0, '0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      step(5'b11111, '0, 1'b0);
      check_val("rr_seq", 32'(bus.mux_in_sel_o), 32'(i % N));
      step(5'b11111, 5'b10000, 1'b0);
      check_val("rr_gap", 32'(bus.grant_vld_o), 32'd0);
    end

    // Reset during a grant
    step('0, '0, 1'b1);
    step(5'b00100, '0, 1'b0);
    check_val("rg_in", 32'(bus.mux_in_sel_o), 32'd2);
    step(5'b00100, '0, 1'b1);
    check_val("rg_gv", 32'(bus.grant_vld_o), 32'd0);
    check_val("rg_in0", 32'(bus.mux_in_sel_o), 32'd0);
    step(5'b11111, '0, 1'b0);
    check_val("rg_next", 32'(bus.mux_in_sel_o), 32'd0);

    // Valid drop keeps the pointer; completion with drop advances it
    step('0, '0, 1'b1);
    step(5'b00100, '0, 1'b0);
    step(5'b00100, 5'b00001, 1'b0);
    step(5'b11111, '0, 1'b0);
    check_val("drop_g3", 32'(bus.mux_in_sel_o), 32'd3);
    step('0, '0, 1'b0);
    check_val("drop_idle", 32'(bus.grant_vld_o), 32'd0);
    step('0, '0, 1'b0);
    step(5'b11111, '0, 1'b0);
    check_val("drop_regrant", 32'(bus.mux_in_sel_o), 32'd3);
    step('0, 5'b01000, 1'b0);
    step(5'b11111, '0, 1'b0);
    check_val("wr_wins", 32'(bus.mux_in_sel_o), 32'd4);

`ifdef ARB_TIMEOUT_EN
    // Watchdog release
    step('0, '0, 1'b1);
    step(5'b00110, '0, 1'b0);
    check_val("to_grant", 32'(bus.mux_in_sel_o), 32'd1);
    for (int i = 0; i < TO - 1; i++) step(5'b00110, '0, 1'b0);
    check_val("to_held", 32'(bus.grant_vld_o), 32'd1);
    step(5'b00110, '0, 1'b0);
    check_val("to_pulse", 32'(bus.timeout_o), 32'd1);
    step(5'b00110, '0, 1'b0);
    check_val("to_next", 32'(bus.mux_in_sel_o), 32'd2);
    check_val("to_clear", 32'(bus.timeout_o), 32'd0);
`endif

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      for (int p = 0; p < N; p++) set_dst(p, $urandom_range(0, 3), $urandom_range(0, 3));
      rv = N'($urandom);
      rw = '0;
      if ($urandom_range(0, 3) == 0) rw = N'($urandom_range(1, (1 << N) - 1));
      step(rv, rw, $urandom_range(0, 49) == 0);
    end

    check_val("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
